// File: rtl/btn_pkg.sv
// Shared types and constants for the multi-channel push-button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: debounce FSM state type with explicit encodings, counter
// wrap/saturate mode selectors.
package btn_pkg;

    // Debounce FSM encodings
    localparam logic [1:0] ENC_REL    = 2'd0;
    localparam logic [1:0] ENC_WAIT_P = 2'd1;
    localparam logic [1:0] ENC_PRS    = 2'd2;
    localparam logic [1:0] ENC_WAIT_R = 2'd3;

    typedef enum logic [1:0] {
        REL    = ENC_REL,     // released, idle
        WAIT_P = ENC_WAIT_P,  // candidate press, counting stable highs
        PRS    = ENC_PRS,     // pressed
        WAIT_R = ENC_WAIT_R   // candidate release, counting stable lows
    } deb_state_t;

    // Counter overflow behaviour, selected by the SAT parameter
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press pulse, level.
// Latency: stable input change -> press/level update DEB_CYCLES+2 edges later.
// Backpressure: none; press is a fire-and-forget one-cycle pulse.
//
// Ports: clk (rising edge), rs (sync active-low reset), btn_raw (async
// button), level (debounced level), press (one-cycle pulse per accepted
// press, and per auto-repeat when AUTO_REPEAT_EN is defined).
// Build option: AUTO_REPEAT_EN adds the hold/repeat counter.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 1000,
    parameter int REP_CYCLES  = 250
) (
    input  logic clk,
    input  logic rs,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    // The counter only ever holds 0..DEB_CYCLES-1: the sample that would
    // reach DEB_CYCLES is the one that triggers the state change.
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);

    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    deb_state_t     state_q, state_d;
    logic [DW-1:0]  deb_cnt_q, deb_cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           rep_press;

    assign sync1_d = btn_raw;
    assign sync2_d = sync1_q;

`ifdef AUTO_REPEAT_EN
    localparam int HMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          rep_q, rep_d;      // 0: waiting for first repeat, 1: repeating
    logic [HW-1:0] hold_nxt;

    // Counts cycles spent in PRS with the button still held; any exit
    // from PRS (or re-entry from WAIT_R) starts the HOLD phase over.
    always_comb begin
        hold_cnt_d = '0;
        rep_d      = 1'b0;
        rep_press  = 1'b0;
        hold_nxt   = hold_cnt_q + HW'(1);
        if (state_q == PRS && sync2_q) begin
            rep_d      = rep_q;
            hold_cnt_d = hold_nxt;
            if (!rep_q && hold_nxt == HW'(HOLD_CYCLES)) begin
                rep_press  = 1'b1;
                rep_d      = 1'b1;
                hold_cnt_d = '0;
            end else if (rep_q && hold_nxt == HW'(REP_CYCLES)) begin
                rep_press  = 1'b1;
                hold_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            hold_cnt_q <= '0;
            rep_q      <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            rep_q      <= rep_d;
        end
    end
`else
    localparam int unused_hold_rep = HOLD_CYCLES + REP_CYCLES;
    assign rep_press = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        case (state_q)
            REL: begin
                if (sync2_q) begin
                    state_d   = WAIT_P;
                    deb_cnt_d = DEB_ONE;
                end
            end
            WAIT_P: begin
                if (sync2_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d   = PRS;
                        deb_cnt_d = '0;
                        level_d   = 1'b1;
                        press_d   = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_ONE;
                    end
                end else begin
                    state_d   = REL;
                    deb_cnt_d = '0;
                end
            end
            PRS: begin
                if (!sync2_q) begin
                    state_d   = WAIT_R;
                    deb_cnt_d = DEB_ONE;
                end else begin
                    press_d   = rep_press;
                end
            end
            WAIT_R: begin
                if (!sync2_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d   = REL;
                        deb_cnt_d = '0;
                        level_d   = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_ONE;
                    end
                end else begin
                    // bounce back: still pressed, no new pulse
                    state_d   = PRS;
                    deb_cnt_d = '0;
                end
            end
            default: begin
                state_d   = REL;
                deb_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rs) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= REL;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/btn_multi.sv
// Multi-channel push-button front end with per-channel press counters.
// Latency: stable press -> press pulse DEB_CYCLES+2 edges, counter +1 edge later.
// Backpressure: none; every accepted press is counted unless clr collides.
//
// Ports: clk, rs (sync active-low reset), btn[CH] raw buttons,
// clr[CH] per-channel counter clear, level[CH] debounced levels,
// press[CH] press pulses, q[CH*WIDTH] counters (channel i at q[i*WIDTH +: WIDTH]).
// Build option: AUTO_REPEAT_EN enables hold-to-repeat in every channel.
module btn_multi
    import btn_pkg::*;
#(
    parameter int CH          = 4,
    parameter int WIDTH       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int SAT         = 0,
    parameter int HOLD_CYCLES = 1000,
    parameter int REP_CYCLES  = 250
) (
    input  logic                clk,
    input  logic                rs,
    input  logic [CH-1:0]       btn,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       press,
    output logic [CH*WIDTH-1:0] q
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;

        btn_debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES),
            .REP_CYCLES  (REP_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rs      (rs),
            .btn_raw (btn[i]),
            .level   (level[i]),
            .press   (press[i])
        );

        // clr wins over a same-cycle press; that press is dropped.
        always_comb begin
            cnt_d = cnt_q;
            if (clr[i]) begin
                cnt_d = '0;
            end else if (press[i]) begin
                if (SAT == CNT_SAT && cnt_q == {WIDTH{1'b1}}) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rs) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign q[i*WIDTH +: WIDTH] = cnt_q;
    end

endmodule

// File: doc/btn_multi.md
# btn_multi

Parametrised multi-channel push-button front end: synchronises, debounces and edge-detects CH raw button inputs, then counts debounced presses per channel into WIDTH-bit counters. It sits between the board push-buttons and the display/control logic, and replaces the single-channel 8-bit button counter. It adds per-channel clear, wrap/saturate counting and optional hold-to-repeat.

## Interface
- CH, 4: number of button channels (1..8)
- WIDTH, 8: press-counter width per channel
- DEB_CYCLES, 16: consecutive stable synchronised samples required to accept a level change (≥2)
- SAT, 0: 0 = counter wraps at 2^WIDTH-1 → 0; 1 = counter holds at 2^WIDTH-1
- HOLD_CYCLES, 1000: cycles held before the first auto-repeat (AUTO_REPEAT_EN only)
- REP_CYCLES, 250: cycles between subsequent auto-repeats (AUTO_REPEAT_EN only)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rs  in  1  synchronous active-low reset
- btn  in  CH  raw asynchronous button inputs, active-high
- clr  in  CH  per-channel synchronous counter clear, active-high
- level  out  CH  debounced button level
- press  out  CH  one-cycle pulse per accepted press (and per repeat)
- q  out  CH*WIDTH  press counters; channel i at q[i*WIDTH +: WIDTH]

## Operation
- Per channel: 2-FF synchroniser → debounce FSM → pulse → counter.
- FSM states: REL (released), WAIT_P (candidate press), PRS (pressed), WAIT_R (candidate release).
- REL: sync=1 → WAIT_P, deb_cnt=1.
- WAIT_P: sync=1 → deb_cnt++. When deb_cnt reaches DEB_CYCLES → PRS, level=1, press=1 for one cycle. sync=0 → REL, deb_cnt=0.
- PRS: sync=0 → WAIT_R, deb_cnt=1.
- WAIT_R: sync=0 → deb_cnt++. When deb_cnt reaches DEB_CYCLES → REL, level=0 (no pulse). sync=1 → PRS.
- Counter: press=1 → q_i+1. Wrap or saturate per SAT.
- clr_i=1 → q_i=0 on the next edge. clr takes priority over a simultaneous press; that press is lost. The FSM is unaffected by clr.
- Channels are fully independent. Simultaneous presses on several channels each count.

## Timing
- Reset (rs=0 at edge): sync FFs=0, state=REL, deb_cnt=0, level=0, press=0, q=0. Reset mid-debounce or mid-hold discards everything.
- Latency: btn rising, held stable → press high DEB_CYCLES+2 edges later. q increments at the edge after press (DEB_CYCLES+3).
- level rises with press. level falls DEB_CYCLES+2 edges after a stable release.
- Glitch shorter than DEB_CYCLES synchronised cycles → no press, level unchanged.
- press is never high on two consecutive cycles.

## Configuration
- AUTO_REPEAT_EN defined: in PRS, hold_cnt runs from the press pulse. At HOLD_CYCLES it emits a repeat press (counted like a real press), then another every REP_CYCLES while still in PRS. Leaving PRS (including to WAIT_R) clears hold_cnt. A bounce back to PRS restarts the HOLD phase.
- Not defined: no hold counter is synthesised; exactly one press per accepted press.

## Structure
- Package btn_pkg: FSM state typedef (REL, WAIT_P, PRS, WAIT_R), state encoding constants, saturate/wrap mode constants.
- Sub-module btn_debounce_ch: synchroniser, FSM, debounce and hold counters, press/level for one channel.
- Top btn_multi: generate-loop over CH instances plus the per-channel counters and clr logic.

## Test plan
- Reset: rs=0 for 3 cycles with btn=all-1 → level=0, press=0, q=0 throughout. After release, press fires DEB_CYCLES+2 cycles later.
- Clean press (DEB_CYCLES=4): btn[0]=1 for 50 cycles → exactly one press pulse at cycle 6, q[0] becomes 1 at cycle 7, level[0] is 1. Release → level falls 6 cycles later, q[0] stays 1.
- Bounce: btn[1] toggles every 2 cycles for 20 cycles, then is held 1 → single press and q[1]=1. A 3-cycle glitch alone → q[1] unchanged.
- Wrap/saturate (WIDTH=2): 5 presses → q=1 with SAT=0, q=3 with SAT=1.
- Clear collision: clr[2]=1 on the same edge that press[2] would increment → q[2]=0. Press on channel 3 at the same time → q[3] increments.
- AUTO_REPEAT_EN (HOLD=10, REP=5, DEB=4): hold btn[0] for 30 cycles after acceptance → presses at acceptance, +10, +15, +20, +25, +30. q[0]=6.
